// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the EX stage. Optional macro FAST_MUL_EN
// replaces the iterative multiplier with a single-cycle combinational one.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            kill,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CW-1:0]     cnt_r, cnt_nxt_s;
    logic [2:0]        op_r, op_nxt_s;
    logic              sgn1_r, sgn1_nxt_s, sgn2_r, sgn2_nxt_s;
    logic [XLEN:0]     acc_r, acc_nxt_s;
    logic [XLEN-1:0]   lo_r, lo_nxt_s;
    logic [XLEN-1:0]   opb_r, opb_nxt_s;
    logic [XLEN-1:0]   result_r, result_nxt_s;
    logic              busy_r, done_r;

    logic              signed1_s, signed2_s, sgn1_s, sgn2_s;
    logic [XLEN-1:0]   abs1_s, abs2_s;
    logic              short_s;
    logic [XLEN-1:0]   short_res_s;
    logic [XLEN:0]     rem_sh_s, diff_s, msum_s;
    logic [XLEN:0]     step_acc_s;
    logic [XLEN-1:0]   step_lo_s;
    logic [XLEN-1:0]   q_fin_s, r_fin_s, final_s;
    logic [2*XLEN-1:0] prod_s, prod_fin_s;
`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fprod_s, fprod_fin_s;
`endif

    // Operand decode: sign flags, magnitudes and the single-cycle special cases.
    always_comb begin
        signed1_s   = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        signed2_s   = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        sgn1_s      = signed1_s & rs1_val[XLEN-1];
        sgn2_s      = signed2_s & rs2_val[XLEN-1];
        abs1_s      = sgn1_s ? (~rs1_val + {{(XLEN-1){1'b0}}, 1'b1}) : rs1_val;
        abs2_s      = sgn2_s ? (~rs2_val + {{(XLEN-1){1'b0}}, 1'b1}) : rs2_val;
        short_s     = 1'b0;
        short_res_s = {XLEN{1'b0}};
`ifdef FAST_MUL_EN
        fprod_s     = {{XLEN{1'b0}}, abs1_s} * {{XLEN{1'b0}}, abs2_s};
        fprod_fin_s = (sgn1_s ^ sgn2_s) ? (~fprod_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : fprod_s;
`endif
        if (op[2] && (rs2_val == {XLEN{1'b0}})) begin
            short_s     = 1'b1;
            short_res_s = op[1] ? rs1_val : {XLEN{1'b1}};
        end else if (op[2] && !op[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                     && (rs2_val == {XLEN{1'b1}})) begin
            short_s     = 1'b1;
            short_res_s = op[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
`ifdef FAST_MUL_EN
        end else if (!op[2]) begin
            short_s     = 1'b1;
            short_res_s = (op[1:0] == 2'b00) ? fprod_fin_s[XLEN-1:0] : fprod_fin_s[2*XLEN-1:XLEN];
`endif
        end else begin
            short_s     = 1'b0;
        end
    end

    // One radix-2 iteration: restoring divide on {acc,lo} or shift-add multiply.
    always_comb begin
        rem_sh_s = {acc_r[XLEN-1:0], lo_r[XLEN-1]};
        diff_s   = rem_sh_s - {1'b0, opb_r};
        msum_s   = {1'b0, acc_r[XLEN-1:0]} + (lo_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
        if (op_r[2]) begin
            if (!diff_s[XLEN]) begin
                step_acc_s = diff_s;
                step_lo_s  = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                step_acc_s = rem_sh_s;
                step_lo_s  = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            step_acc_s = {1'b0, msum_s[XLEN:1]};
            step_lo_s  = {msum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Sign correction and result selection for the last iteration.
    always_comb begin
        q_fin_s    = (sgn1_r ^ sgn2_r) ? (~step_lo_s + {{(XLEN-1){1'b0}}, 1'b1}) : step_lo_s;
        r_fin_s    = sgn1_r ? (~step_acc_s[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                            : step_acc_s[XLEN-1:0];
        prod_s     = {step_acc_s[XLEN-1:0], step_lo_s};
        prod_fin_s = (sgn1_r ^ sgn2_r) ? (~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_s;
        if (op_r[2]) begin
            final_s = op_r[1] ? r_fin_s : q_fin_s;
        end else if (op_r[1:0] == 2'b00) begin
            final_s = prod_fin_s[XLEN-1:0];
        end else begin
            final_s = prod_fin_s[2*XLEN-1:XLEN];
        end
    end

    // FSM next-state and datapath register updates.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        op_nxt_s     = op_r;
        sgn1_nxt_s   = sgn1_r;
        sgn2_nxt_s   = sgn2_r;
        acc_nxt_s    = acc_r;
        lo_nxt_s     = lo_r;
        opb_nxt_s    = opb_r;
        result_nxt_s = result_r;
        case (state_r)
            ST_IDLE: begin
                if (kill) begin
                    state_nxt_s = ST_IDLE;
                end else if (start) begin
                    op_nxt_s   = op;
                    sgn1_nxt_s = sgn1_s;
                    sgn2_nxt_s = sgn2_s;
                    if (short_s) begin
                        result_nxt_s = short_res_s;
                        state_nxt_s  = ST_DONE;
                    end else begin
                        state_nxt_s = ST_CALC;
                        cnt_nxt_s   = {CW{1'b0}};
                        acc_nxt_s   = {(XLEN+1){1'b0}};
                        lo_nxt_s    = op[2] ? abs1_s : abs2_s;
                        opb_nxt_s   = op[2] ? abs2_s : abs1_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    acc_nxt_s = step_acc_s;
                    lo_nxt_s  = step_lo_s;
                    if (cnt_r == CW'(XLEN-1)) begin
                        result_nxt_s = final_s;
                        state_nxt_s  = ST_DONE;
                        cnt_nxt_s    = {CW{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            op_r     <= 3'd0;
            sgn1_r   <= 1'b0;
            sgn2_r   <= 1'b0;
            acc_r    <= {(XLEN+1){1'b0}};
            lo_r     <= {XLEN{1'b0}};
            opb_r    <= {XLEN{1'b0}};
            result_r <= {XLEN{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            op_r     <= op_nxt_s;
            sgn1_r   <= sgn1_nxt_s;
            sgn2_r   <= sgn2_nxt_s;
            acc_r    <= acc_nxt_s;
            lo_r     <= lo_nxt_s;
            opb_r    <= opb_nxt_s;
            result_r <= result_nxt_s;
            busy_r   <= (state_nxt_s == ST_CALC);
            done_r   <= (state_nxt_s == ST_DONE);
        end
    end

    // Stall drops in the same cycle as a kill so the flush is not held off.
    assign stall_req = (((state_r == ST_IDLE) & start & ~short_s) | (state_r == ST_CALC)) & ~kill;
    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_val = 32'd0;
    logic [31:0] rs2_val = 32'd0;
    logic        kill = 1'b0;
    logic        stall_req, busy, done;
    logic [31:0] result;

    int total = 0;
    int bad = 0;
    logic [31:0] last_res = 32'd0;

`ifdef FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .kill(kill),
        .stall_req(stall_req), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sbu;
        logic [63:0] ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sbu = {32'd0, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * sbu; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_short(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o < 3'd4) return FAST;
        if (b == 32'd0) return 1'b1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int lat;
        int n;
        exp = model(o, a, b);
        lat = is_short(o, a, b) ? 0 : 32;
        op = o; rs1_val = a; rs2_val = b; start = 1'b1;
        #1;
        total++;
        if (stall_req !== (lat != 0)) begin
            bad++;
            $display("FAIL stall_at_start op=%0d got=%b want=%b", o, stall_req, (lat != 0));
        end
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            total++;
            if (stall_req !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL calc_flags op=%0d cyc=%0d got stall=%b busy=%b want 1 1", o, n, stall_req, busy);
            end
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n !== lat) begin
            bad++;
            $display("FAIL latency op=%0d got=%0d want=%0d", o, n, lat);
        end
        total++;
        if (result !== exp) begin
            bad++;
            $display("FAIL result op=%0d a=%h b=%h got=%h want=%h", o, a, b, result, exp);
        end
        total++;
        if (stall_req !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_flags op=%0d got stall=%b busy=%b want 0 0", o, stall_req, busy);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle op=%0d got=%b want=0", o, done);
        end
        last_res = exp;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || stall_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got busy=%b done=%b result=%h stall=%b want 0 0 0 0", busy, done, result, stall_req);
        end
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_div_basic();
        run_op(3'd4, 32'd100, 32'd7);
        run_op(3'd6, 32'd100, 32'd7);
        run_op(3'd6, 32'hFFFF_FF9C, 32'd7);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd4, 32'hFFFF_FF9C, 32'd7);
        run_op(3'd7, 32'hFFFF_FFFF, 32'd10);
    endtask

    task automatic test_short();
        run_op(3'd5, 32'd5, 32'd0);
        run_op(3'd7, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF0, 32'd0);
        run_op(3'd6, 32'hFFFF_FFF0, 32'd0);
    endtask

    task automatic test_mul();
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
        run_op(3'd1, 32'hFFFF_FFFD, 32'd5);
    endtask

    task automatic test_kill();
        logic [31:0] keep;
        int pulses;
        keep = last_res;
        op = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        kill = 1'b1;
        #1;
        total++;
        if (stall_req !== 1'b0) begin
            bad++;
            $display("FAIL kill_stall_drop got=%b want=0", stall_req);
        end
        @(posedge clk); #1;
        kill = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== keep) begin
            bad++;
            $display("FAIL kill_idle got busy=%b done=%b result=%h want 0 0 %h", busy, done, result, keep);
        end
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) pulses++; end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL kill_no_done got=%0d want=0", pulses);
        end
        run_op(3'd4, 32'd9, 32'd3);
    endtask

    task automatic test_reset_mid();
        int pulses;
        op = 3'd5; rs1_val = 32'd12345; rs2_val = 32'd17; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || stall_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got busy=%b done=%b result=%h stall=%b want 0 0 0 0", busy, done, result, stall_req);
        end
        #2;
        rst_n = 1'b1;
        last_res = 32'd0;
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) pulses++; end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL reset_no_done got=%0d want=0", pulses);
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] exp;
        int n;
        exp = model(3'd4, 32'd5000, 32'd13);
        op = 3'd4; rs1_val = 32'd5000; rs2_val = 32'd13; start = 1'b1;
        @(posedge clk); #1;
        op = 3'd5; rs1_val = 32'd77; rs2_val = 32'd0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        start = 1'b0;
        total++;
        if (n !== 32 || result !== exp) begin
            bad++;
            $display("FAIL start_ignored got lat=%0d result=%h want lat=32 result=%h", n, result, exp);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL start_in_done got done=%b busy=%b want 0 0", done, busy);
        end
        last_res = exp;
    endtask

    task automatic test_kill_start();
        op = 3'd5; rs1_val = 32'd8; rs2_val = 32'd0; start = 1'b1; kill = 1'b1;
        #1;
        total++;
        if (stall_req !== 1'b0) begin
            bad++;
            $display("FAIL kill_start_stall got=%b want=0", stall_req);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== last_res) begin
            bad++;
            $display("FAIL kill_start_short got done=%b busy=%b result=%h want 0 0 %h", done, busy, result, last_res);
        end
        op = 3'd4; rs1_val = 32'd50; rs2_val = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL kill_start_long got done=%b busy=%b want 0 0", done, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [2:0] o;
        logic [31:0] a, b;
        int sel;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            else if (sel == 3) a = 32'($urandom_range(0, 255));
            run_op(o, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_div_basic();
        test_short();
        test_mul();
        test_kill();
        test_reset_mid();
        test_start_ignored();
        test_kill_start();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
